// File: rtl/y86_pkg.sv
// Shared Y86 definitions for the execute stage: instruction codes,
// ALU function codes, condition selectors and the condition-code type.
package y86_pkg;

  // Instruction codes used by the execute back end
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;

  // ALU function codes (ifun of OPq)
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  // Condition selectors (ifun of jXX / cmovXX)
  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

  // "No register" destination
  localparam logic [3:0] REG_NONE = 4'hF;

  // Condition-code register, packed as {ZF,SF,OF}
  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

  // Occupancy of the 1-deep E->M register; out_valid is this state
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } em_state_t;

endpackage

// File: rtl/exec_cc_stage_cond_eval.sv
// cond_eval: combinational jXX/cmovXX condition from the CC register and ifun.
// Selectors above C_G evaluate to 0.
module cond_eval
  import y86_pkg::*;
(
  input  cc_t        cc,
  input  logic [3:0] ifun,
  output logic       cnd
);

  logic lt;
  assign lt = cc.sf ^ cc.of;

  // Decode the condition selector
  always_comb begin
    cnd = 1'b0;
    case (ifun)
      C_ALWAYS: cnd = 1'b1;
      C_LE:     cnd = lt | cc.zf;
      C_L:      cnd = lt;
      C_E:      cnd = cc.zf;
      C_NE:     cnd = ~cc.zf;
      C_GE:     cnd = ~lt;
      C_G:      cnd = ~lt & ~cc.zf;
      default:  cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_cc_stage.sv
// exec_cc_stage: Y86 execute back end. Generates ZF/SF/OF from the ALU
// result, owns the CC register, evaluates jXX/cmovXX conditions and
// registers valE plus sideband into a 1-deep E->M register.
// Optional feature macro: EXEC_CC_SUPPRESS_EN adds exc_suppress, which
// blocks the CC write of an accepted instruction.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready = !out_valid | out_ready, so it depends on out_ready
// only. While out_valid=1 and out_ready=0 every output holds stable. flush
// overrides everything: the next cycle has out_valid=0 and no CC write.
module exec_cc_stage
  import y86_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_icode,
  input  logic [3:0]       in_ifun,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_res,
  input  logic [WIDTH-1:0] in_valA,
  input  logic [3:0]       in_dstE,
  input  logic [3:0]       in_dstM,
  input  logic             set_cc,
  input  logic             flush,
`ifdef EXEC_CC_SUPPRESS_EN
  input  logic             exc_suppress,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_icode,
  output logic [WIDTH-1:0] out_valE,
  output logic [WIDTH-1:0] out_valA,
  output logic [3:0]       out_dstE,
  output logic [3:0]       out_dstM,
  output logic             out_cnd,
  output logic [2:0]       cc
);

  em_state_t state_q, state_d;
  cc_t       cc_q;
  cc_t       flags;
  logic      accept;
  logic      load;
  logic      cc_we;
  logic      cnd_raw;
  logic      cnd;
  logic      sa, sb, sr;

  assign in_ready  = (state_q == ST_EMPTY) | out_ready;
  assign accept    = in_valid & in_ready;
  assign load      = accept & ~flush;
  assign out_valid = (state_q == ST_FULL);
  assign cc        = cc_q;

`ifdef EXEC_CC_SUPPRESS_EN
  assign cc_we = load & set_cc & ~exc_suppress;
`else
  assign cc_we = load & set_cc;
`endif

  assign sa = alu_a[WIDTH-1];
  assign sb = alu_b[WIDTH-1];
  assign sr = alu_res[WIDTH-1];

  // Flags from the ALU result; OF only meaningful for add/sub
  always_comb begin
    flags.zf = (alu_res == '0);
    flags.sf = sr;
    flags.of = 1'b0;
    case (in_ifun)
      ALU_ADD: flags.of = (sa == sb) & (sr != sb);
      ALU_SUB: flags.of = (sa != sb) & (sr != sb);
      default: flags.of = 1'b0;
    endcase
  end

  // Condition is evaluated on the current CC, not on the flags above
  cond_eval u_cond_eval (
    .cc   (cc_q),
    .ifun (in_ifun),
    .cnd  (cnd_raw)
  );

  assign cnd = ((in_icode == I_CMOVXX) | (in_icode == I_JXX)) & cnd_raw;

  // Next occupancy of the E->M register; flush wins over accept
  always_comb begin
    state_d = state_q;
    if (flush)
      state_d = ST_EMPTY;
    else if (accept)
      state_d = ST_FULL;
    else if (out_ready)
      state_d = ST_EMPTY;
  end

  // Occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= ST_EMPTY;
    else
      state_q <= state_d;
  end

  // Condition-code register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cc_q <= CC_RESET;
    else if (cc_we)
      cc_q <= flags;
  end

  // E->M payload, loaded only on a non-flushed accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_icode <= 4'h0;
      out_valE  <= '0;
      out_valA  <= '0;
      out_dstE  <= REG_NONE;
      out_dstM  <= REG_NONE;
      out_cnd   <= 1'b0;
    end else if (load) begin
      out_icode <= in_icode;
      out_valE  <= alu_res;
      out_valA  <= in_valA;
      out_dstE  <= ((in_icode == I_CMOVXX) & ~cnd) ? REG_NONE : in_dstE;
      out_dstM  <= in_dstM;
      out_cnd   <= cnd;
    end
  end

endmodule

// File: tb/tb_exec_cc_stage.sv
// Directed testbench for exec_cc_stage with hand-computed expectations.
module tb_exec_cc_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_icode;
  logic [3:0]  in_ifun;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [63:0] alu_res;
  logic [63:0] in_valA;
  logic [3:0]  in_dstE;
  logic [3:0]  in_dstM;
  logic        set_cc;
  logic        flush;
  logic        exc_suppress;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_icode;
  logic [63:0] out_valE;
  logic [63:0] out_valA;
  logic [3:0]  out_dstE;
  logic [3:0]  out_dstM;
  logic        out_cnd;
  logic [2:0]  cc;

  int n_checks;
  int n_errors;

  exec_cc_stage #(.WIDTH(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_icode     (in_icode),
    .in_ifun      (in_ifun),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_res      (alu_res),
    .in_valA      (in_valA),
    .in_dstE      (in_dstE),
    .in_dstM      (in_dstM),
    .set_cc       (set_cc),
    .flush        (flush),
`ifdef EXEC_CC_SUPPRESS_EN
    .exc_suppress (exc_suppress),
`endif
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_icode    (out_icode),
    .out_valE     (out_valE),
    .out_valA     (out_valA),
    .out_dstE     (out_dstE),
    .out_dstM     (out_dstM),
    .out_cnd      (out_cnd),
    .cc           (cc)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] res, input logic [3:0] dste,
                       input logic sc);
    in_valid = 1'b1;
    in_icode = icode;
    in_ifun  = ifun;
    alu_a    = a;
    alu_b    = b;
    alu_res  = res;
    in_dstE  = dste;
    set_cc   = sc;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    set_cc   = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_icode = 4'h0; in_ifun = 4'h0;
    alu_a = '0; alu_b = '0; alu_res = '0; in_valA = '0;
    in_dstE = 4'hF; in_dstM = 4'hF; set_cc = 1'b0; flush = 1'b0;
    exc_suppress = 1'b0; out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_cc",        cc, 3'b100);
    check("rst_dstE",      out_dstE, 4'hF);
    check("rst_dstM",      out_dstM, 4'hF);
    check("rst_valE",      out_valE, 0);
    check("rst_cnd",       out_cnd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("idle_out_valid", out_valid, 0);
    check("idle_cc",        cc, 3'b100);
    check("idle_dstE",      out_dstE, 4'hF);
    check("idle_in_ready",  in_ready, 1);

    // OPq xor: 69 ^ -96 = -27, SF=1
    drive(4'h6, 4'h3, 64'd69, -64'sd96, 64'hFFFF_FFFF_FFFF_FFE5, 4'h2, 1'b1);
    in_valA = 64'hA5; in_dstM = 4'h5;
    tick();
    check("xor_valid", out_valid, 1);
    check("xor_valE",  out_valE, 64'hFFFF_FFFF_FFFF_FFE5);
    check("xor_dstE",  out_dstE, 4'h2);
    check("xor_dstM",  out_dstM, 4'h5);
    check("xor_valA",  out_valA, 64'hA5);
    check("xor_icode", out_icode, 4'h6);
    check("xor_cc",    cc, 3'b010);
    check("xor_cnd",   out_cnd, 0);

    // Sub overflow: 0x8000.. - 1 = 0x7FFF.., OF=1
    in_dstM = 4'hF;
    drive(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 4'h4, 1'b1);
    tick();
    check("sub_cc", cc, 3'b001);
    // jl immediately after sees the new flags: SF^OF = 1
    drive(4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0);
    tick();
    check("jl_cnd", out_cnd, 1);
    // je: ZF=0
    drive(4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0);
    tick();
    check("je_cnd", out_cnd, 0);
    check("je_cc_kept", cc, 3'b001);
    // jXX with ifun 7 never taken
    drive(4'h7, 4'h7, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0);
    tick();
    check("j7_cnd", out_cnd, 0);
    // unconditional cmov (rrmovq) keeps dstE
    drive(4'h2, 4'h0, 64'd0, 64'd0, 64'h55, 4'h3, 1'b0);
    tick();
    check("rrmov_cnd",  out_cnd, 1);
    check("rrmov_dstE", out_dstE, 4'h3);

    // cmove with ZF=0: not taken, dstE squashed
    drive(4'h2, 4'h3, 64'd0, 64'd0, 64'h1234, 4'h3, 1'b0);
    tick();
    check("cmove_cnd",  out_cnd, 0);
    check("cmove_dstE", out_dstE, 4'hF);
    check("cmove_valE", out_valE, 64'h1234);

    // Backpressure: add 5 + -5 = 0 waits while the cmove entry is held
    out_ready = 1'b0;
    drive(4'h6, 4'h0, 64'd5, -64'sd5, 64'd0, 4'h6, 1'b1);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", in_ready, 0);
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_valE",  out_valE, 64'h1234);
      check("bp_dstE",  out_dstE, 4'hF);
      check("bp_cc",    cc, 3'b001);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    tick();
    check("bp_acc_valE", out_valE, 0);
    check("bp_acc_dstE", out_dstE, 4'h6);
    check("bp_acc_cc",   cc, 3'b100);
    idle();
    tick();
    check("drain_valid", out_valid, 0);

    // Flush with a valid OPq: nothing captured, cc unchanged
    drive(4'h6, 4'h0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 4'h1, 1'b1);
    flush = 1'b1;
    tick();
    check("flush_valid", out_valid, 0);
    check("flush_cc",    cc, 3'b100);
    // Flush also kills a held entry even without out_ready
    flush = 1'b0;
    tick();
    check("pre_kill_cc", cc, 3'b010);
    idle();
    out_ready = 1'b0;
    flush = 1'b1;
    tick();
    check("kill_held_valid", out_valid, 0);
    flush = 1'b0;
    out_ready = 1'b1;

`ifdef EXEC_CC_SUPPRESS_EN
    // Suppressed OPq: output registered, cc unchanged
    drive(4'h6, 4'h1, 64'd3, 64'd3, 64'd0, 4'h2, 1'b1);
    exc_suppress = 1'b1;
    tick();
    check("sup_valid", out_valid, 1);
    check("sup_valE",  out_valE, 0);
    check("sup_cc",    cc, 3'b010);
    exc_suppress = 1'b0;
    idle();
    tick();
`endif

    // Async reset mid-transfer discards the held entry at once
    drive(4'h6, 4'h2, 64'd0, 64'd0, 64'd0, 4'h2, 1'b1);
    out_ready = 1'b0;
    tick();
    check("pre_rst_valid", out_valid, 1);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_cc",    cc, 3'b100);
    check("async_rst_dstE",  out_dstE, 4'hF);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
